// File: rtl/bin_to_bcd_seq_pkg.sv
// rtl/bin_to_bcd_seq_pkg.sv - shared types and constants for the binary-to-BCD converter
// Purpose: FSM state encoding and BCD/display constants shared with the display driver.
// Ports: none (package).
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int DIGITS            = 4;
    localparam int MAX_VAL           = 9999;
    localparam int BCD_W             = 16;
    localparam logic [3:0] BLANK_NIBBLE = 4'hF;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// rtl/bin_to_bcd_seq_if.sv - request/result bundle between a requester and the converter
// Purpose: groups the conversion request and result signals.
// Ports: start, bin_in (requester -> converter); busy, done, bcd_out, ovf (converter -> requester).
interface bin_to_bcd_seq_if #(
    parameter int BIN_W = 14
);
    import bin_to_bcd_seq_pkg::*;

    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [BCD_W-1:0] bcd_out;
    logic             ovf;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  bcd_out,
        input  ovf
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output bcd_out,
        output ovf
    );

endinterface

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// rtl/bin_to_bcd_seq_bcd_digit_adj.sv - one shift-and-add-3 correction cell for a BCD digit
// Purpose: a digit of 5 or more gets +3 so that the following left shift carries correctly.
// Ports: digit_in (4-bit BCD digit), digit_out (corrected digit, 4-bit wrap, no carry out).
module bcd_digit_adj (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential binary-to-BCD converter, one input bit per clock
// Purpose: converts bin_in to 4-digit packed BCD; values above MAX_VAL give all-blank digits.
// Ports: clk (rising edge), rst_n (synchronous, active-low),
//        bus (slave): start, bin_in in; busy, done (1-cycle), bcd_out[15:0], ovf out.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = bin_to_bcd_seq_pkg::MAX_VAL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bin_to_bcd_seq_if.slave       bus
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

    state_t           state;
    state_t           state_nx;
    logic [BIN_W-1:0] shift_reg;
    logic [BCD_W-1:0] scratch;
    logic [BCD_W-1:0] scratch_adj;
    logic [CNT_W-1:0] bit_cnt;
    logic             ovf_pend;

    // Correct every digit before the shift that doubles it.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scratch[4*d +: 4]),
            .digit_out (scratch_adj[4*d +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SHIFT;
            SHIFT:   if (bit_cnt == LAST_BIT) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            scratch     <= '0;
            bit_cnt     <= '0;
            ovf_pend    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.bcd_out <= '0;
            bus.ovf     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg <= bus.bin_in;
                        scratch   <= '0;
                        bit_cnt   <= '0;
                        // Kept even when BIN_W makes overflow impossible.
                        ovf_pend  <= (32'(bus.bin_in) > 32'(MAX_VAL));
                        bus.busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    // {scratch, shift_reg} << 1 with the corrected digits, MSB first.
                    scratch   <= {scratch_adj[BCD_W-2:0], shift_reg[BIN_W-1]};
                    shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + 1'b1;
                end
                FINISH: begin
                    bus.bcd_out <= ovf_pend ? {DIGITS{BLANK_NIBBLE}} : scratch;
                    bus.ovf     <= ovf_pend;
                    bus.done    <= 1'b1;
                    bus.busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 14;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        if (v > 9999) return 16'hFFFF;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // bcd_out may only move on a done cycle or as a result of reset.
    logic        rst_seen;
    logic [15:0] prev_bcd;
    always @(posedge clk) rst_seen <= rst_n;
    always @(negedge clk) begin
        if (rst_seen === 1'b1 && bus.done !== 1'b1)
            check("hold", bus.bcd_out, prev_bcd);
        prev_bcd = bus.bcd_out;
    end

    // One conversion; noise scrambles start/bin_in while busy.
    task automatic run_conv(input int v, input bit noise);
        int n;
        int busy_cnt;
        bus.bin_in = 14'(v);
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (noise) begin
                bus.start  = 1'($urandom);
                bus.bin_in = 14'($urandom);
                if (n == 14) bus.start = 1'b1;
            end
            @(posedge clk); #1;
            n++;
            if (bus.done !== 1'b1 && bus.busy === 1'b1) busy_cnt++;
        end
        bus.start = 1'b0;
        check("latency", n, 15);
        check("busy_len", busy_cnt, 15);
        check("busy_at_done", bus.busy, 1'b0);
        check("bcd_out", bus.bcd_out, ref_bcd(v));
        check("ovf", bus.ovf, (v > 9999) ? 1 : 0);
        @(posedge clk); #1;
        check("done_pulse", bus.done, 1'b0);
        check("no_reaccept", bus.busy, 1'b0);
    endtask

    initial begin
        int k;
        int t;
        int last;
        int dones;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_ovf", bus.ovf, 1'b0);
        check("rst_bcd", bus.bcd_out, 16'h0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_conv(0, 0);
        run_conv(1234, 0);
        run_conv(9999, 0);
        run_conv(10000, 0);
        run_conv(16383, 0);
        run_conv(42, 0);
        run_conv(5678, 1);

        // Reset during a conversion at edge E7.
        run_conv(1234, 0);
        bus.bin_in = 14'd777;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_bcd", bus.bcd_out, 16'h0000);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
        run_conv(777, 0);

        // start held high: one result every 16 cycles.
        bus.bin_in = 14'd0;
        bus.start  = 1'b1;
        @(posedge clk); #1;
        k = 0;
        t = 0;
        last = 0;
        while (k < 4 && t < 100) begin
            @(posedge clk); #1;
            t++;
            if (bus.done === 1'b1) begin
                check("b2b_val", bus.bcd_out, ref_bcd(k));
                check("b2b_gap", t - last, (k == 0) ? 15 : 16);
                last = t;
                k++;
                bus.bin_in = 14'(k);
                if (k == 4) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("b2b_count", k, 4);
        @(posedge clk); #1;

        // Randomized values, biased around the overflow boundary.
        for (int i = 0; i < 30; i++) begin
            int v;
            case ($urandom_range(0, 2))
                0:       v = $urandom_range(0, 16383);
                1:       v = $urandom_range(9990, 10010);
                default: v = $urandom_range(0, 99);
            endcase
            run_conv(v, i[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
